// File: rtl/set_mode_pkg.sv
// Shared types and defaults for the set-mode controller: mode encoding,
// button-lock owner, registered event bundle and mode decode helpers.
package set_mode_pkg;

    // Externally visible mode encoding
    typedef enum logic [2:0] {
        MODE_IDLE = 3'd0,
        MODE_T_HH = 3'd1,
        MODE_T_MM = 3'd2,
        MODE_A_HH = 3'd3,
        MODE_A_MM = 3'd4
    } mode_e;

    // Which button currently owns the input lock
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_B1   = 2'd1,
        OWN_B2   = 2'd2,
        OWN_B3   = 2'd3
    } owner_e;

    // Accepted button events, bit 0 = b1, bit 1 = b2, bit 2 = b3
    typedef struct packed {
        logic [2:0] short_ev;
        logic [2:0] long_ev;
        logic [1:0] rpt;       // auto-repeat ticks for b1/b2 only
    } evt_t;

    localparam int unsigned LONG_CYC_DEF    = 16;
    localparam int unsigned REPEAT_CYC_DEF  = 4;
    localparam int unsigned TIMEOUT_CYC_DEF = 64;

    // Press and repeat counters cover 1..255, the idle timeout 2..65535
    localparam int CNT_W = 8;
    localparam int TMO_W = 16;

    function automatic logic is_time_mode(input mode_e m);
        return (m == MODE_T_HH) || (m == MODE_T_MM);
    endfunction

    function automatic logic is_alarm_mode(input mode_e m);
        return (m == MODE_A_HH) || (m == MODE_A_MM);
    endfunction

    function automatic logic is_minutes_mode(input mode_e m);
        return (m == MODE_T_MM) || (m == MODE_A_MM);
    endfunction

endpackage

// File: rtl/press_classifier.sv
// Per-button press classifier: counts consecutive high cycles (saturating at
// LONG_CYC) and flags a one-cycle long event when the count reaches LONG_CYC,
// or a one-cycle short event on the first low cycle after a shorter press.
// A button seen high when reset releases stays disarmed until it reads low.
module press_classifier
    import set_mode_pkg::*;
#(
    parameter int unsigned LONG_CYC = LONG_CYC_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic active,
    output logic short_ev,
    output logic long_ev
);

    localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYC);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;

    assign active = armed_q & btn;

    // Count armed high cycles and classify the press at its long point or release
    always_comb begin
        // NOTE: every always_comb output is defaulted first so no latch is inferred.
        cnt_d    = cnt_q;
        armed_d  = armed_q | ~btn;
        short_ev = 1'b0;
        long_ev  = 1'b0;
        if (active) begin
            if (cnt_q != LONG_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (cnt_q == LONG_LAST) begin
                long_ev = 1'b1;
            end
        end else begin
            short_ev = (cnt_q != '0) && (cnt_q != LONG_MAX);
            cnt_d    = '0;
        end
    end

    // Press counter and arm flag; reset disarms so a held button cannot fire
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: flops use non-blocking assignments and clear asynchronously, so a
        // reset mid-press drops the partial count instead of finishing it later.
        if (!reset) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/set_mode_ctrl.sv
// Clock/alarm set-mode controller. Three press classifiers feed a lock stage
// (first-pressed button owns the inputs until all are released, b3 > b1 > b2
// on ties) and an auto-repeat generator; accepted events are registered once,
// then a registered FSM turns them into mode changes and single-cycle strobes.
module set_mode_ctrl
    import set_mode_pkg::*;
#(
    parameter int unsigned LONG_CYC    = LONG_CYC_DEF,
    parameter int unsigned REPEAT_CYC  = REPEAT_CYC_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       b1_d,
    input  logic       b2_d,
    input  logic       b3_d,
    input  logic       alarm_ring,
    output logic [2:0] mode,
    output logic       set_time,
    output logic       set_alarm,
    output logic       field_sel,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       commit_pulse,
    output logic       stop_pulse,
    output logic       led
);

    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [2:0] btn;
    logic [2:0] active;
    logic [2:0] short_raw;
    logic [2:0] long_raw;
    logic [2:0] own_mask;

    owner_e           owner_q, owner_d;
    evt_t             evt_q, evt_d;
    logic [1:0]       rep_q, rep_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;

    mode_e            mode_q, mode_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             inc_d, dec_d, commit_d, stop_d;
    logic             set_time_q, set_alarm_q, field_sel_q, led_q;
    logic             inc_q, dec_q, commit_q, stop_q;

    assign btn = {b3_d, b2_d, b1_d};

    for (genvar i = 0; i < 3; i++) begin : g_btn
        press_classifier #(
            .LONG_CYC (LONG_CYC)
        ) u_press (
            .clock    (clock),
            .reset    (reset),
            .btn      (btn[i]),
            .active   (active[i]),
            .short_ev (short_raw[i]),
            .long_ev  (long_raw[i])
        );
    end

    // Input lock, event gating and auto-repeat for the owning b1/b2 button
    always_comb begin
        owner_d   = owner_q;
        rep_d     = rep_q;
        rep_cnt_d = rep_cnt_q;

        case (owner_q)
            OWN_B1:  own_mask = 3'b001;
            OWN_B2:  own_mask = 3'b010;
            OWN_B3:  own_mask = 3'b100;
            default: own_mask = 3'b000;
        endcase

        if (owner_q == OWN_NONE) begin
            if (active[2]) begin
                owner_d = OWN_B3;
            end else if (active[0]) begin
                owner_d = OWN_B1;
            end else if (active[1]) begin
                owner_d = OWN_B2;
            end
        end else if (btn == 3'b000) begin
            // The owner's release event is still gated by owner_q this cycle
            owner_d = OWN_NONE;
        end

        evt_d.short_ev = short_raw & own_mask;
        evt_d.long_ev  = long_raw & own_mask;
        evt_d.rpt      = 2'b00;

        // Repeat only starts from a long press made inside a set state
        if (mode_q == MODE_IDLE) begin
            rep_d     = 2'b00;
            rep_cnt_d = '0;
        end else if (evt_d.long_ev[1:0] != 2'b00) begin
            rep_d     = evt_d.long_ev[1:0];
            rep_cnt_d = '0;
        end else if ((rep_q & btn[1:0]) != 2'b00) begin
            if (rep_cnt_q == REP_LAST) begin
                evt_d.rpt = rep_q;
                rep_cnt_d = '0;
            end else begin
                rep_cnt_d = rep_cnt_q + CNT_W'(1);
            end
        end else begin
            rep_d     = 2'b00;
            rep_cnt_d = '0;
        end
    end

    // Lock owner, accepted-event register and repeat counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner_q   <= OWN_NONE;
            evt_q     <= '0;
            rep_q     <= 2'b00;
            rep_cnt_q <= '0;
        end else begin
            owner_q   <= owner_d;
            evt_q     <= evt_d;
            rep_q     <= rep_d;
            rep_cnt_q <= rep_cnt_d;
        end
    end

    // Mode transitions, strobes and idle timeout from the registered events
    always_comb begin
        mode_d   = mode_q;
        tmo_d    = '0;
        inc_d    = 1'b0;
        dec_d    = 1'b0;
        commit_d = 1'b0;
        stop_d   = 1'b0;

        case (mode_q)
            MODE_IDLE: begin
                if (evt_q.long_ev[0]) begin
                    mode_d = MODE_T_HH;
                end else if (evt_q.long_ev[1]) begin
                    mode_d = MODE_A_HH;
                end else if (evt_q.short_ev[2] && alarm_ring) begin
                    stop_d = 1'b1;
                end
            end
            MODE_T_HH, MODE_T_MM, MODE_A_HH, MODE_A_MM: begin
                if (evt_q.long_ev[2]) begin
                    mode_d = MODE_IDLE;
                end else if (evt_q.short_ev[2]) begin
                    case (mode_q)
                        MODE_T_HH: mode_d = MODE_T_MM;
                        MODE_A_HH: mode_d = MODE_A_MM;
                        default: begin
                            mode_d   = MODE_IDLE;
                            commit_d = 1'b1;
                        end
                    endcase
                end else if (evt_q.short_ev[0] || evt_q.long_ev[0] || evt_q.rpt[0]) begin
                    inc_d = 1'b1;
                end else if (evt_q.short_ev[1] || evt_q.long_ev[1] || evt_q.rpt[1]) begin
                    dec_d = 1'b1;
                end

                if ((mode_d != mode_q) || (btn != 3'b000)) begin
                    tmo_d = '0;
                end else if (tmo_q == TMO_LAST) begin
                    mode_d = MODE_IDLE;
                    inc_d  = 1'b0;
                    dec_d  = 1'b0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: mode_d = MODE_IDLE;
        endcase
    end

    // Mode FSM state with every output registered from the next mode
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_q      <= MODE_IDLE;
            tmo_q       <= '0;
            set_time_q  <= 1'b0;
            set_alarm_q <= 1'b0;
            field_sel_q <= 1'b0;
            led_q       <= 1'b0;
            inc_q       <= 1'b0;
            dec_q       <= 1'b0;
            commit_q    <= 1'b0;
            stop_q      <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            tmo_q       <= tmo_d;
            set_time_q  <= is_time_mode(mode_d);
            set_alarm_q <= is_alarm_mode(mode_d);
            field_sel_q <= is_minutes_mode(mode_d);
            led_q       <= (mode_d != MODE_IDLE);
            inc_q       <= inc_d;
            dec_q       <= dec_d;
            commit_q    <= commit_d;
            stop_q      <= stop_d;
        end
    end

    assign mode         = mode_q;
    assign set_time     = set_time_q;
    assign set_alarm    = set_alarm_q;
    assign field_sel    = field_sel_q;
    assign led          = led_q;
    assign inc_pulse    = inc_q;
    assign dec_pulse    = dec_q;
    assign commit_pulse = commit_q;
    assign stop_pulse   = stop_q;

endmodule

// File: tb/tb_set_mode_ctrl.sv
// Bench for set_mode_ctrl: directed timing checks plus random single-button
// presses scored against a press-level model (mode and pulse counts per press).
module tb_set_mode_ctrl;

    localparam int L = 16;
    localparam int R = 4;
    localparam int T = 64;

    logic       clock = 1'b0;
    logic       reset;
    logic       b1_d, b2_d, b3_d, alarm_ring;
    logic [2:0] mode;
    logic       set_time, set_alarm, field_sel;
    logic       inc_pulse, dec_pulse, commit_pulse, stop_pulse, led;

    int checks = 0;
    int errors = 0;
    int n_inc, n_dec, n_commit, n_stop;
    int model_mode;

    always #5 clock = ~clock;

    set_mode_ctrl #(
        .LONG_CYC    (L),
        .REPEAT_CYC  (R),
        .TIMEOUT_CYC (T)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .b1_d         (b1_d),
        .b2_d         (b2_d),
        .b3_d         (b3_d),
        .alarm_ring   (alarm_ring),
        .mode         (mode),
        .set_time     (set_time),
        .set_alarm    (set_alarm),
        .field_sel    (field_sel),
        .inc_pulse    (inc_pulse),
        .dec_pulse    (dec_pulse),
        .commit_pulse (commit_pulse),
        .stop_pulse   (stop_pulse),
        .led          (led)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: sample just after the edge, tally strobes, check invariants
    task automatic step();
        @(posedge clock);
        #1;
        n_inc    += int'(inc_pulse);
        n_dec    += int'(dec_pulse);
        n_commit += int'(commit_pulse);
        n_stop   += int'(stop_pulse);
        check("pulse_excl", 32'((inc_pulse & dec_pulse) | ((inc_pulse | dec_pulse) & commit_pulse)), 0);
        check("led_vs_mode", 32'(led), 32'(mode != 3'd0));
    endtask

    task automatic clr();
        n_inc = 0; n_dec = 0; n_commit = 0; n_stop = 0;
    endtask

    task automatic set_btn(input int idx, input logic v);
        case (idx)
            1: b1_d = v;
            2: b2_d = v;
            default: b3_d = v;
        endcase
    endtask

    task automatic press(input int idx, input int n);
        set_btn(idx, 1'b1);
        repeat (n) step();
        set_btn(idx, 1'b0);
        repeat (3) step();
    endtask

    task automatic check_state(input string tag, input int m);
        check({tag, "_mode"},      32'(mode),      32'(m));
        check({tag, "_set_time"},  32'(set_time),  32'(m == 1 || m == 2));
        check({tag, "_set_alarm"}, 32'(set_alarm), 32'(m == 3 || m == 4));
        check({tag, "_field_sel"}, 32'(field_sel), 32'(m == 2 || m == 4));
    endtask

    // Press-level reference: outcome of one isolated press of n cycles
    task automatic model_press(input int idx, input int n);
        int  e_inc, e_dec, e_commit, e_stop;
        bit  lng;
        e_inc = 0; e_dec = 0; e_commit = 0; e_stop = 0;
        lng = (n >= L);
        clr();
        press(idx, n);
        case (idx)
            1: if (model_mode == 0) begin
                   if (lng) model_mode = 1;
               end else begin
                   e_inc = lng ? 1 + (n - L) / R : 1;
               end
            2: if (model_mode == 0) begin
                   if (lng) model_mode = 3;
               end else begin
                   e_dec = lng ? 1 + (n - L) / R : 1;
               end
            default: if (model_mode == 0) begin
                   e_stop = (!lng && alarm_ring) ? 1 : 0;
               end else if (lng) begin
                   model_mode = 0;
               end else if (model_mode == 1) begin
                   model_mode = 2;
               end else if (model_mode == 3) begin
                   model_mode = 4;
               end else begin
                   model_mode = 0;
                   e_commit   = 1;
               end
        endcase
        check("press_inc",    n_inc,    e_inc);
        check("press_dec",    n_dec,    e_dec);
        check("press_commit", n_commit, e_commit);
        check("press_stop",   n_stop,   e_stop);
        check_state("press", model_mode);
    endtask

    initial begin
        int hits[$];
        reset = 1'b0; b1_d = 1'b0; b2_d = 1'b0; b3_d = 1'b0; alarm_ring = 1'b0;
        model_mode = 0;
        clr();

        // Reset state
        repeat (3) step();
        check_state("reset", 0);
        check("reset_pulses", 32'({inc_pulse, dec_pulse, commit_pulse, stop_pulse}), 0);
        reset = 1'b1;
        repeat (2) step();

        // Long b1 from IDLE: mode changes one cycle after the 16th high cycle
        clr();
        b1_d = 1'b1;
        repeat (16) step();
        check("long_b1_before", 32'(mode), 0);
        step();
        check("long_b1_mode", 32'(mode), 1);
        check("long_b1_set_time", 32'(set_time), 1);
        repeat (3) step();
        b1_d = 1'b0;
        repeat (3) step();
        check("long_b1_no_inc", n_inc, 0);
        model_mode = 1;
        check_state("t_hh", 1);

        // Short presses and short/long boundary in T_HH
        model_press(1, 5);
        model_press(2, 5);
        model_press(1, 15);
        model_press(1, 16);
        model_press(1, 20);
        model_press(2, 19);
        model_press(3, 20);   // long b3 aborts
        model_press(1, 5);    // short b1 ignored in IDLE
        model_press(2, 20);   // into A_HH

        // Auto-repeat timing while b2 is held 30 cycles in A_HH
        clr();
        b2_d = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (dec_pulse) hits.push_back(k - 1);
        end
        b2_d = 1'b0;
        repeat (3) step();
        check("rpt_count", hits.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("rpt_at", (i < hits.size()) ? hits[i] : -1, 16 + 4 * i);
        end
        check("rpt_total", n_dec, 4);
        check_state("rpt", 3);

        model_press(3, 2);    // A_MM
        model_press(1, 3);
        model_press(3, 2);    // commit back to IDLE

        // Time set walk: hours -> minutes -> commit
        model_press(1, 20);
        model_press(3, 2);
        model_press(3, 2);

        // Timeout in T_MM, entered on the edge two cycles after b3 release
        model_press(1, 20);
        model_press(3, 2);
        clr();
        repeat (T - 2) step();
        check("tmo_hold", 32'(mode), 2);
        step();
        check("tmo_fire", 32'(mode), 0);
        check("tmo_no_commit", n_commit, 0);
        model_mode = 0;

        // Alarm stop from IDLE
        alarm_ring = 1'b1;
        model_press(3, 3);
        model_press(3, 20);
        alarm_ring = 1'b0;
        model_press(3, 3);

        // Lock: same-cycle b1+b2 -> b1 wins
        clr();
        b1_d = 1'b1; b2_d = 1'b1;
        repeat (20) step();
        b1_d = 1'b0; b2_d = 1'b0;
        repeat (3) step();
        model_mode = 1;
        check_state("lock_b1b2", 1);
        check("lock_b1b2_dec", n_dec, 0);
        // Same-cycle b3+b1 -> b3 wins
        clr();
        b1_d = 1'b1; b3_d = 1'b1;
        repeat (3) step();
        b1_d = 1'b0; b3_d = 1'b0;
        repeat (3) step();
        model_mode = 2;
        check_state("lock_b3b1", 2);
        check("lock_b3b1_inc", n_inc, 0);
        // b2 first, b1 overlapping and released last -> only b2 counts
        clr();
        b2_d = 1'b1;
        repeat (2) step();
        b1_d = 1'b1;
        repeat (3) step();
        b2_d = 1'b0;
        repeat (2) step();
        b1_d = 1'b0;
        repeat (3) step();
        check("lock_first_dec", n_dec, 1);
        check("lock_first_inc", n_inc, 0);
        check_state("lock_first", 2);
        model_press(3, 20);

        // Reset mid-repeat with b1 held through deassertion
        model_press(1, 20);
        clr();
        b1_d = 1'b1;
        repeat (22) step();
        check("pre_reset_inc", n_inc, 2);
        reset = 1'b0;
        step();
        check_state("mid_reset", 0);
        check("mid_reset_inc", 32'(inc_pulse), 0);
        step();
        reset = 1'b1;
        clr();
        repeat (25) step();
        b1_d = 1'b0;
        repeat (4) step();
        check("held_reset_inc", n_inc, 0);
        check_state("held_reset", 0);
        model_mode = 0;
        model_press(1, 3);
        model_press(1, 20);
        model_press(1, 3);

        // Random isolated presses against the press-level model
        for (int i = 0; i < 60; i++) begin
            alarm_ring = 1'($urandom_range(0, 1));
            model_press(int'($urandom_range(1, 3)), int'($urandom_range(1, 30)));
            repeat ($urandom_range(0, 4)) step();
        end
        alarm_ring = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
